ob_rsp_serializer: RTL and testbench

// Egress stage directly downstream of the order-book engine. Accepts ob_pkg::rsp_t

---
 rtl/ob_rsp_serializer.sv | 155 +++++++++++++++
 tb/tb_ob_rsp_serializer.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ob_rsp_serializer.sv
// Egress serializer for order-book responses: a small response FIFO feeding a
// byte-wide framer that emits 15-byte frames, MSB first.
//
// state | meaning
// IDLE  | no frame in flight; loads the FIFO head as soon as one is present
// SEND  | presenting shreg[119:112] as frame byte idx; reloads at idx 14
module ob_rsp_serializer #(
  parameter int RSP_FIFO_N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rsp_vld,
  input  logic [114:0] rsp,
  output logic         rsp_rdy,
  output logic         out_vld,
  output logic [7:0]   out_dat,
  output logic         out_sop,
  output logic         out_eop,
  input  logic         out_rdy,
  output logic         busy
);

  localparam int FRAME_BYTES = 15;
  localparam int RSP_W       = 115;
  localparam int SHREG_W     = 8 * FRAME_BYTES;
  localparam int PW          = $clog2(RSP_FIFO_N);
  localparam int CW          = PW + 1;
  localparam logic [3:0]    LAST_IDX = 4'(FRAME_BYTES - 1);
  localparam logic [CW-1:0] OCC_FULL = CW'(RSP_FIFO_N);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [1:0]         rst_sync;
  logic               rst_int_n;
  logic [RSP_W-1:0]   fifo_mem [RSP_FIFO_N];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      occ;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               load;
  logic               shift;
  logic [RSP_W-1:0]   head;
  logic [SHREG_W-1:0] shreg;
  logic [3:0]         idx;

  // Assert asynchronously, release on a clock edge so no flop sees a runt deassert.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync[1];

  assign fifo_full  = (occ == OCC_FULL);
  assign fifo_empty = (occ == '0);
  assign push       = rsp_vld & ~fifo_full;
  assign head       = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= rsp;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        occ <= occ + 1'b1;
      end else if (!push && pop) begin
        occ <= occ - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          load      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (out_rdy) begin
          if (idx != LAST_IDX) begin
            shift = 1'b1;
          end else if (!fifo_empty) begin
            // Reload on the last byte so consecutive frames have no bubble.
            pop  = 1'b1;
            load = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame order is {pad, status, uid, result}; the input word is {uid, status, result}.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      shreg <= '0;
      idx   <= '0;
    end else if (load) begin
      shreg <= {5'b00000, head[82:80], head[114:83], head[79:0]};
      idx   <= '0;
    end else if (shift) begin
      shreg <= {shreg[SHREG_W-9:0], 8'h00};
      idx   <= idx + 1'b1;
    end
  end

  assign out_vld = (state == SEND);
  assign out_dat = out_vld ? shreg[SHREG_W-1 -: 8] : 8'h00;
  assign out_sop = out_vld & (idx == 4'd0);
  assign out_eop = out_vld & (idx == LAST_IDX);
  assign rsp_rdy = ~fifo_full;
  assign busy    = ~fifo_empty | out_vld;

endmodule

// File: tb/tb_ob_rsp_serializer.sv
// Directed bench for ob_rsp_serializer: frame contents, backpressure, FIFO full,
// mid-frame reset and pointer wrap with hand-built expected byte streams.
module tb_ob_rsp_serializer;

  logic         clk;
  logic         rst_n;
  logic         rsp_vld;
  logic [114:0] rsp;
  logic         rsp_rdy;
  logic         out_vld;
  logic [7:0]   out_dat;
  logic         out_sop;
  logic         out_eop;
  logic         out_rdy;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] got_dat [$];
  logic       got_sop [$];
  logic       got_eop [$];
  logic [114:0] exp_rsp [$];

  ob_rsp_serializer #(.RSP_FIFO_N(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rsp_vld (rsp_vld),
    .rsp     (rsp),
    .rsp_rdy (rsp_rdy),
    .out_vld (out_vld),
    .out_dat (out_dat),
    .out_sop (out_sop),
    .out_eop (out_eop),
    .out_rdy (out_rdy),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [114:0] mk(input logic [31:0] uid, input logic [2:0] st,
                                      input logic [79:0] res);
    return {uid, st, res};
  endfunction

  // Expected frame byte i for a response word {uid, status, result}.
  function automatic logic [7:0] exp_byte(input logic [114:0] r, input int i);
    logic [119:0] f;
    f = {5'b00000, r[82:80], r[114:83], r[79:0]};
    f = f >> (8 * (14 - i));
    return f[7:0];
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic push_one(input logic [114:0] r);
    rsp_vld = 1'b1;
    rsp     = r;
    @(posedge clk); #1;
    rsp_vld = 1'b0;
  endtask

  task automatic collect(input int n, input int maxc, output int gaps, output int cyc);
    int start;
    start = got_dat.size();
    gaps  = 0;
    cyc   = 0;
    while ((got_dat.size() - start) < n && cyc < maxc) begin
      out_rdy = 1'b1;
      if (out_vld) begin
        got_dat.push_back(out_dat);
        got_sop.push_back(out_sop);
        got_eop.push_back(out_eop);
      end else begin
        gaps++;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic clear_capture();
    got_dat.delete();
    got_sop.delete();
    got_eop.delete();
    exp_rsp.delete();
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    rsp_vld = 1'b0;
    rsp     = '0;
    out_rdy = 1'b0;
    #12;
    n_checks++;
    if ({out_vld, out_sop, out_eop, out_dat, busy, rsp_rdy} !== {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_outputs: got vld=%b sop=%b eop=%b dat=%h busy=%b rdy=%b expected 0 0 0 00 0 1",
               out_vld, out_sop, out_eop, out_dat, busy, rsp_rdy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({out_vld, busy, rsp_rdy} !== 3'b001) begin
      n_fail++;
      $display("FAIL post_reset_idle: got vld=%b busy=%b rdy=%b expected 0 0 1", out_vld, busy, rsp_rdy);
    end
  endtask

  task automatic test_single_frame();
    logic [7:0] exp1 [15];
    int gaps, cyc;
    exp1 = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hAB, 8'h00, 8'h00, 8'h00,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    clear_capture();
    out_rdy = 1'b1;
    push_one(mk(32'h0000_00AB, 3'b000, 80'h0));
    n_checks++;
    if ({out_vld, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL latency_t1: got vld=%b busy=%b expected vld=0 busy=1", out_vld, busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({out_vld, out_sop, out_dat} !== {1'b1, 1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL latency_t2: got vld=%b sop=%b dat=%h expected 1 1 00", out_vld, out_sop, out_dat);
    end
    collect(15, 40, gaps, cyc);
    n_checks++;
    if (got_dat.size() != 15) begin
      n_fail++;
      $display("FAIL single_count: got %0d bytes expected 15", got_dat.size());
    end else begin
      for (int i = 0; i < 15; i++) begin
        n_checks++;
        if ({got_dat[i], got_sop[i], got_eop[i]} !== {exp1[i], i == 0, i == 14}) begin
          n_fail++;
          $display("FAIL single_byte%0d: got dat=%h sop=%b eop=%b expected %h %b %b",
                   i, got_dat[i], got_sop[i], got_eop[i], exp1[i], i == 0, i == 14);
        end
      end
    end
    n_checks++;
    if ({out_vld, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_idle: got vld=%b busy=%b expected 0 0", out_vld, busy);
    end
  endtask

  task automatic test_back_to_back();
    int g1, c1, g2, c2;
    logic [114:0] r;
    clear_capture();
    out_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      r = mk(32'hA0B0_C0D0 ^ 32'(k), 3'(k), {8'(k + 1), 72'h01_0203_0405_0607_0809});
      n_checks++;
      if (rsp_rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_rdy_push%0d: got %b expected 1", k, rsp_rdy);
      end
      exp_rsp.push_back(r);
      push_one(r);
    end
    n_checks++;
    if ({rsp_rdy, busy, out_vld} !== 3'b011) begin
      n_fail++;
      $display("FAIL b2b_full: got rdy=%b busy=%b vld=%b expected 0 1 1", rsp_rdy, busy, out_vld);
    end
    // Offered while full: must be refused.
    rsp_vld = 1'b1;
    rsp     = mk(32'hFFFF_FFFF, 3'b111, 80'hFF);
    repeat (3) @(posedge clk);
    #1;
    rsp_vld = 1'b0;
    collect(14, 30, g1, c1);
    n_checks++;
    if ({rsp_rdy, out_eop} !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_rdy_during_pop: got rdy=%b eop=%b expected 0 1", rsp_rdy, out_eop);
    end
    collect(61, 120, g2, c2);
    n_checks++;
    if (got_dat.size() != 75 || (g1 + g2) != 0 || (c1 + c2) != 75) begin
      n_fail++;
      $display("FAIL b2b_stream: got bytes=%0d gaps=%0d cycles=%0d expected 75 0 75",
               got_dat.size(), g1 + g2, c1 + c2);
    end else begin
      for (int i = 0; i < 75; i++) begin
        n_checks++;
        if ({got_dat[i], got_sop[i], got_eop[i]} !==
            {exp_byte(exp_rsp[i / 15], i % 15), (i % 15) == 0, (i % 15) == 14}) begin
          n_fail++;
          $display("FAIL b2b_byte%0d: got dat=%h sop=%b eop=%b expected %h", i,
                   got_dat[i], got_sop[i], got_eop[i], exp_byte(exp_rsp[i / 15], i % 15));
        end
      end
    end
    n_checks++;
    if ({out_vld, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_drained: got vld=%b busy=%b expected 0 0", out_vld, busy);
    end
  endtask

  task automatic test_status_fields();
    logic [7:0] exp3 [15];
    int gaps, cyc;
    exp3 = '{8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45,
             8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h00, 8'h11};
    clear_capture();
    out_rdy = 1'b1;
    push_one(mk(32'hDEAD_BEEF, 3'b101, 80'h0123_4567_89AB_CDEF_0011));
    collect(15, 40, gaps, cyc);
    n_checks++;
    if (got_dat.size() != 15) begin
      n_fail++;
      $display("FAIL status_count: got %0d bytes expected 15", got_dat.size());
    end else begin
      for (int i = 0; i < 15; i++) begin
        n_checks++;
        if (got_dat[i] !== exp3[i]) begin
          n_fail++;
          $display("FAIL status_byte%0d: got %h expected %h", i, got_dat[i], exp3[i]);
        end
      end
    end
  endtask

  task automatic test_random_backpressure();
    logic       prev_vld, prev_rdy, prev_sop, prev_eop;
    logic [7:0] prev_dat;
    logic [114:0] r;
    int cyc;
    clear_capture();
    out_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      r = mk($urandom, 3'($urandom_range(0, 7)), {16'($urandom), $urandom, $urandom});
      exp_rsp.push_back(r);
      push_one(r);
    end
    prev_vld = 1'b0;
    prev_rdy = 1'b0;
    prev_dat = 8'h00;
    prev_sop = 1'b0;
    prev_eop = 1'b0;
    cyc = 0;
    while (got_dat.size() < 45 && cyc < 500) begin
      if (prev_vld && !prev_rdy) begin
        n_checks++;
        if ({out_vld, out_dat, out_sop, out_eop} !== {1'b1, prev_dat, prev_sop, prev_eop}) begin
          n_fail++;
          $display("FAIL stall_hold: got vld=%b dat=%h sop=%b eop=%b expected 1 %h %b %b",
                   out_vld, out_dat, out_sop, out_eop, prev_dat, prev_sop, prev_eop);
        end
      end
      out_rdy = 1'($urandom_range(0, 1));
      if (out_vld && out_rdy) begin
        got_dat.push_back(out_dat);
        got_sop.push_back(out_sop);
        got_eop.push_back(out_eop);
      end
      prev_vld = out_vld;
      prev_rdy = out_rdy;
      prev_dat = out_dat;
      prev_sop = out_sop;
      prev_eop = out_eop;
      @(posedge clk); #1;
      cyc++;
    end
    out_rdy = 1'b0;
    n_checks++;
    if (got_dat.size() != 45) begin
      n_fail++;
      $display("FAIL random_count: got %0d bytes expected 45", got_dat.size());
    end else begin
      for (int i = 0; i < 45; i++) begin
        n_checks++;
        if ({got_dat[i], got_sop[i], got_eop[i]} !==
            {exp_byte(exp_rsp[i / 15], i % 15), (i % 15) == 0, (i % 15) == 14}) begin
          n_fail++;
          $display("FAIL random_byte%0d: got %h expected %h", i, got_dat[i],
                   exp_byte(exp_rsp[i / 15], i % 15));
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int gaps, cyc, vld_seen;
    clear_capture();
    out_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push_one(mk(32'h5555_0000 + 32'(k), 3'b010, 80'hAAAA));
    end
    collect(7, 20, gaps, cyc);
    out_rdy = 1'b0;
    n_checks++;
    if ({out_vld, out_sop, out_eop, got_dat.size() == 7} !== 4'b1001) begin
      n_fail++;
      $display("FAIL midrst_setup: got vld=%b sop=%b eop=%b bytes=%0d expected 1 0 0 7",
               out_vld, out_sop, out_eop, got_dat.size());
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_vld, out_sop, out_eop, out_dat, busy, rsp_rdy} !== {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL midrst_async: got vld=%b sop=%b eop=%b dat=%h busy=%b rdy=%b expected 0 0 0 00 0 1",
               out_vld, out_sop, out_eop, out_dat, busy, rsp_rdy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    vld_seen = 0;
    for (int c = 0; c < 30; c++) begin
      out_rdy = 1'b1;
      if (out_vld || busy || !rsp_rdy) vld_seen++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (vld_seen != 0) begin
      n_fail++;
      $display("FAIL midrst_quiet: got %0d active cycles expected 0", vld_seen);
    end
  endtask

  task automatic test_push_pop_same_cycle();
    logic [114:0] r;
    int pushes_left, cyc, rdy_low, gaps, k;
    clear_capture();
    out_rdy = 1'b0;
    for (int j = 0; j < 3; j++) begin
      r = mk(32'hC000_0000 + 32'(j), 3'(j), 80'(j * 7 + 1));
      exp_rsp.push_back(r);
      push_one(r);
    end
    pushes_left = 20;
    k       = 3;
    cyc     = 0;
    rdy_low = 0;
    gaps    = 0;
    while (got_dat.size() < 345 && cyc < 700) begin
      out_rdy = 1'b1;
      if (!rsp_rdy) rdy_low++;
      if (out_vld && out_eop && pushes_left > 0) begin
        r = mk(32'hC000_0000 + 32'(k), 3'(k), 80'(k * 7 + 1) ^ {$urandom, 48'h0});
        exp_rsp.push_back(r);
        rsp_vld = 1'b1;
        rsp     = r;
        pushes_left--;
        k++;
      end else begin
        rsp_vld = 1'b0;
      end
      if (out_vld) begin
        got_dat.push_back(out_dat);
        got_sop.push_back(out_sop);
        got_eop.push_back(out_eop);
      end else begin
        gaps++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    rsp_vld = 1'b0;
    n_checks++;
    if (got_dat.size() != 345 || gaps != 0 || rdy_low != 0) begin
      n_fail++;
      $display("FAIL wrap_stream: got bytes=%0d gaps=%0d rdy_low=%0d expected 345 0 0",
               got_dat.size(), gaps, rdy_low);
    end else begin
      for (int i = 0; i < 345; i++) begin
        n_checks++;
        if ({got_dat[i], got_sop[i], got_eop[i]} !==
            {exp_byte(exp_rsp[i / 15], i % 15), (i % 15) == 0, (i % 15) == 14}) begin
          n_fail++;
          $display("FAIL wrap_byte%0d: got %h expected %h", i, got_dat[i],
                   exp_byte(exp_rsp[i / 15], i % 15));
        end
      end
    end
    n_checks++;
    if ({out_vld, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL wrap_drained: got vld=%b busy=%b expected 0 0", out_vld, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_status_fields();
    test_random_backpressure();
    test_reset_mid_frame();
    test_push_pop_same_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
